acc_drain: RTL

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/acc_drain_if.sv | 28 ++
 rtl/acc_drain.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/acc_drain_if.sv
// Output stream bundle for acc_drain: processed accumulator beats with a
// valid/ready handshake plus index and last-beat markers.
interface acc_drain_if #(
  parameter int OUT_WIDTH      = 8,
  parameter int ACC_ADDR_WIDTH = 4
);
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_WIDTH-1:0]      out_data;
  logic [ACC_ADDR_WIDTH-1:0] out_index;
  logic                      out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/acc_drain.sv
// acc_drain: walks every accumulator of a MATRIX_SIZE x MATRIX_SIZE systolic
// array, applies an arithmetic right shift and narrows each value to
// OUT_WIDTH bits, and streams the results out over a valid/ready handshake.
//
// Optional feature macro: ACC_DRAIN_SAT_EN
//   defined   -> narrowing saturates to the signed OUT_WIDTH range
//   undefined -> narrowing keeps the low OUT_WIDTH bits (wrap)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; index held at 0
// S_READ  | addressing accumulators, loading the output register
// S_FLUSH | last beat loaded, waiting for its handshake
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module acc_drain #(
  parameter int MATRIX_SIZE    = 3,
  parameter int ACC_WIDTH      = 32,
  parameter int OUT_WIDTH      = 8,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [4:0]                  shift_amt,
  output logic [ACC_ADDR_WIDTH-1:0]   addr_acc,
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  acc_drain_if.master                 out_if,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_ACC = MATRIX_SIZE * MATRIX_SIZE;
  localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX = ACC_ADDR_WIDTH'(NUM_ACC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic [ACC_ADDR_WIDTH-1:0] idx_q;
  logic [4:0]                shift_q;
  logic                      valid_q;
  logic [OUT_WIDTH-1:0]      data_q;
  logic [ACC_ADDR_WIDTH-1:0] index_q;
  logic                      last_q;
  logic                      done_q;

  logic signed [ACC_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]        data_d;
  logic                        load;

  assign shifted = acc_in >>> shift_q;

  // A new beat may enter the output register when it is empty or draining.
  assign load = (state_q == S_READ) && (!valid_q || out_if.out_ready);

`ifdef ACC_DRAIN_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Clamp the shifted value into the signed output range.
  always_comb begin
    data_d = OUT_WIDTH'(shifted);
    if (shifted > SAT_MAX) begin
      data_d = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      data_d = SAT_MIN[OUT_WIDTH-1:0];
    end
  end
`else
  // Keep only the low output bits of the shifted value.
  always_comb begin
    data_d = OUT_WIDTH'(shifted);
  end
`endif

  // Drain sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            idx_q   <= '0;
            shift_q <= shift_amt;
          end
        end
        S_READ: begin
          if (load) begin
            data_q  <= data_d;
            index_q <= idx_q;
            last_q  <= (idx_q == LAST_IDX);
            valid_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= S_FLUSH;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (valid_q && out_if.out_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_acc         = idx_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_index = index_q;
  assign out_if.out_last  = last_q;

endmodule
